sdram_cmd_mon: RTL and testbench
================================

Name: sdram_cmd_mon

Overview:
- Synthesizable device-side monitor for the SDRAM command bus. It is the receiving end of the `{cs_n,ras_n,cas_n,we_n}` / `ba` / `addr` interface driven by the init, auto-refresh, write and read controllers.
- Decodes every command and tracks per-bank open/closed state.
- Checks tRP, tRFC and tRCD spacing, refresh-while-open, activate-while-open and the maximum refresh interval.
- Reports violations as one-cycle pulses and as sticky flags. Used in the SDRAM testbench and optionally left in silicon for debug.

Parameters:
- `TRP_CLK`, 2: minimum cycles from PRECHARGE to the next non-NOP command.
- `TRFC_CLK`, 7: minimum cycles from AUTO_REFRESH to the next non-NOP command.
- `TRCD_CLK`, 2: minimum cycles from ACTIVE on a bank to READ/WRITE on that bank.
- `REF_MAX_CLK`, 1562: maximum cycles allowed between consecutive AUTO_REFRESH commands after init.

Ports:
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst_n`  in  1  asynchronous reset, active low.
- `init_end`  in  1  SDRAM initialisation finished; stays high once set.
- `cmd`  in  4  `{cs_n,ras_n,cas_n,we_n}` as presented to the SDRAM.
- `ba`  in  2  bank address.
- `addr`  in  13  A12-A0; A10 selects precharge-all.
- `err_clr`  in  1  clears `err_sticky`.
- `err_pulse`  out  6  one-cycle violation strobes: [0] tRP, [1] tRFC, [2] tRCD/closed-bank access, [3] refresh with bank open, [4] ACTIVE to open bank, [5] refresh late.
- `err_sticky`  out  6  accumulated `err_pulse`.
- `ref_cnt`  out  16  count of AUTO_REFRESH commands accepted after `init_end`.
- `bank_open`  out  4  per-bank open flag.
- `mon_state`  out  2  current monitor state.

Behaviour:
- Decode table:
  - `cs_n`=1 or 0111: NOP.
  - 0010: PRECHARGE.
  - 0001: AUTO_REFRESH.
  - 0011: ACTIVE.
  - 0101: READ.
  - 0100: WRITE.
  - 0000: LOAD_MODE.
  - 0110: BURST_STOP, treated as NOP for timing.
- Reset (async, `sys_rst_n`=0): all outputs 0, state MON_IDLE, all counters 0. Reset mid-operation discards all tracking immediately.
- States:
  - MON_IDLE (0): no checking, `bank_open` held 0. Goes to MON_READY on the first cycle `init_end`=1; the command sampled in that same cycle is ignored.
  - MON_READY (1): no timing window open. PRECHARGE goes to MON_TRP; AUTO_REFRESH goes to MON_TRFC; other commands stay.
  - MON_TRP (2): `gap` counts cycles since PRECHARGE; the command cycle is `gap`=0.
    - A non-NOP command while `gap`<`TRP_CLK` pulses [0]; that command is still decoded and acted on.
    - At `gap`=`TRP_CLK`-1 with NOP, go to MON_READY.
    - A legal non-NOP command is processed as if in MON_READY.
  - MON_TRFC (3): same structure with `TRFC_CLK` and flag [1]. AUTO_REFRESH at `gap`>=`TRFC_CLK` restarts MON_TRFC, which is a legal back-to-back refresh.
- Bank tracking:
  - ACTIVE sets `bank_open[ba]`; if that bit is already 1, pulse [4].
  - PRECHARGE with A10=1 clears all bits; with A10=0 it clears `bank_open[ba]`.
  - AUTO_REFRESH with any `bank_open` bit set pulses [3].
- tRCD:
  - Each bank has a 3-bit saturating counter, reset to 0 on ACTIVE to that bank.
  - READ/WRITE pulses [2] if the bank is closed or its counter < `TRCD_CLK`.
- Refresh interval:
  - A 12-bit counter `ref_gap` clears on AUTO_REFRESH, otherwise increments and saturates at 4095.
  - It is held at 0 in MON_IDLE.
  - When `ref_gap` reaches `REF_MAX_CLK`, pulse [5] exactly once. It re-arms on the next AUTO_REFRESH.
- Outputs:
  - `err_pulse` is registered and appears on the cycle after the offending command sample.
  - Multiple bits may assert together.
  - `err_sticky` <= (`err_sticky` & ~{6{`err_clr`}}) | `err_pulse`, so a new pulse wins over a simultaneous clear.
  - `ref_cnt` increments on each AUTO_REFRESH in a non-IDLE state and wraps 65535 to 0.
  - `bank_open` and `mon_state` are registered.

Test Plan:
- Reset low, `init_end`=0, drive PRECHARGE then AUTO_REFRESH back-to-back → no `err_pulse`, `ref_cnt`=0, `mon_state`=0; raise `init_end` → `mon_state`=1 next cycle.
- Legal refresh burst: PRE(A10=1), NOP, NOP, AR, 7×NOP, AR → `err_pulse`=0, `ref_cnt`=2, final state MON_TRFC then MON_READY.
- PRE followed by AR at `gap`=1 → `err_pulse`=6'b000001 for one cycle, `err_sticky[0]`=1; then `err_clr`=1 for one cycle → `err_sticky`=0.
- ACTIVE `ba`=2; READ `ba`=2 at `gap` 1 → [2] pulses; second ACTIVE `ba`=2 → [4]; AR with bank 2 open → [3]; PRE A10=0 `ba`=2 → `bank_open`=0.
- After `init_end`, one AR then 1562 NOP cycles → [5] pulses exactly once at `ref_gap`=1562 and stays low through 4095 saturation; next AR re-arms.
- Assert `sys_rst_n`=0 mid MON_TRFC with `err_sticky`≠0 → all outputs 0 in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/sdram_cmd_mon.sv
// SDRAM command-bus monitor.
// Decodes {cs_n,ras_n,cas_n,we_n}/ba/addr, tracks which banks are open, and
// flags tRP, tRFC and tRCD spacing errors, refresh or activate hazards on open
// banks, and late refreshes.
// Each violation is reported as a one-cycle strobe and as a sticky flag.
module sdram_cmd_mon #(
  parameter int TRP_CLK     = 2,
  parameter int TRFC_CLK    = 7,
  parameter int TRCD_CLK    = 2,
  parameter int REF_MAX_CLK = 1562
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic [3:0]  cmd,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  input  logic        err_clr,
  output logic [5:0]  err_pulse,
  output logic [5:0]  err_sticky,
  output logic [15:0] ref_cnt,
  output logic [3:0]  bank_open,
  output logic [1:0]  mon_state
);

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_READY = 2'd1,
    MON_TRP   = 2'd2,
    MON_TRFC  = 2'd3
  } mon_state_t;

  localparam logic [7:0]  TRP_LIM  = 8'(TRP_CLK);
  localparam logic [7:0]  TRFC_LIM = 8'(TRFC_CLK);
  localparam logic [3:0]  TRCD_LIM = 4'(TRCD_CLK);
  localparam logic [11:0] REF_LIM  = 12'(REF_MAX_CLK);

  mon_state_t  state_reg, state_next;
  logic [7:0]  gap_reg, gap_next;
  logic [3:0]  bank_open_reg, bank_open_next;
  logic [11:0] ref_gap_reg, ref_gap_next;
  logic        late_armed_reg, late_armed_next;
  logic [15:0] ref_cnt_reg, ref_cnt_next;
  logic [5:0]  err_pulse_reg, err_next;
  logic [5:0]  err_sticky_reg;
  logic [2:0]  trcd_reg [4];

  logic is_pre, is_ar, is_act, is_rd, is_wr, is_lmr, is_timed;
  logic [3:0] trcd_elapsed;

  // Only A10 is meaningful to the monitor; the remaining address bits are
  // folded here so they are visibly accounted for.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[12:11], addr[9:0]};

  // Command decode; cs_n high, NOP and BURST_STOP leave every strobe low.
  always_comb begin
    is_pre = 1'b0;
    is_ar  = 1'b0;
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_lmr = 1'b0;
    if (!cmd[3]) begin
      case (cmd[2:0])
        3'b010:  is_pre = 1'b1;
        3'b001:  is_ar  = 1'b1;
        3'b011:  is_act = 1'b1;
        3'b101:  is_rd  = 1'b1;
        3'b100:  is_wr  = 1'b1;
        3'b000:  is_lmr = 1'b1;
        default: ;
      endcase
    end
  end

  // Any command other than NOP/BURST_STOP counts against the tRP/tRFC windows.
  assign is_timed = is_pre | is_ar | is_act | is_rd | is_wr | is_lmr;

  // The counter is zeroed by the register update that follows ACTIVE.
  // Counter value + 1 is therefore the number of cycles since ACTIVE, where the
  // ACTIVE cycle itself counts as 0.
  assign trcd_elapsed = {1'b0, trcd_reg[ba]} + 4'd1;

  // Next-state, bank tracking, refresh interval and violation decode.
  always_comb begin
    state_next      = state_reg;
    gap_next        = gap_reg;
    bank_open_next  = bank_open_reg;
    ref_gap_next    = ref_gap_reg;
    late_armed_next = late_armed_reg;
    ref_cnt_next    = ref_cnt_reg;
    err_next        = '0;

    if (state_reg == MON_IDLE) begin
      // Nothing is tracked before init completes. The command sampled in the
      // same cycle as init_end is ignored.
      gap_next       = '0;
      bank_open_next = '0;
      ref_gap_next   = '0;
      if (init_end) begin
        state_next = MON_READY;
      end
    end else begin
      // Timing windows: count idle cycles, flag early commands.
      case (state_reg)
        MON_TRP: begin
          if (!is_timed) begin
            gap_next = (gap_reg == 8'hFF) ? gap_reg : gap_reg + 8'd1;
            if (gap_reg >= TRP_LIM - 8'd1) begin
              state_next = MON_READY;
            end
          end else if (gap_reg < TRP_LIM) begin
            err_next[0] = 1'b1;
          end
        end
        MON_TRFC: begin
          if (!is_timed) begin
            gap_next = (gap_reg == 8'hFF) ? gap_reg : gap_reg + 8'd1;
            if (gap_reg >= TRFC_LIM - 8'd1) begin
              state_next = MON_READY;
            end
          end else if (gap_reg < TRFC_LIM) begin
            err_next[1] = 1'b1;
          end
        end
        default: ;
      endcase

      // A command is acted on as if the monitor were in MON_READY.
      // This also applies to a command that arrived too early.
      if (is_timed) begin
        state_next = MON_READY;
        gap_next   = '0;
        if (is_pre) begin
          state_next = MON_TRP;
          gap_next   = 8'd1;
        end
        if (is_ar) begin
          state_next = MON_TRFC;
          gap_next   = 8'd1;
        end
      end

      if (is_act) begin
        err_next[4]        = bank_open_reg[ba];
        bank_open_next[ba] = 1'b1;
      end

      if (is_pre) begin
        if (addr[10]) begin
          bank_open_next = '0;
        end else begin
          bank_open_next[ba] = 1'b0;
        end
      end

      if (is_rd || is_wr) begin
        if (!bank_open_reg[ba] || (trcd_elapsed < TRCD_LIM)) begin
          err_next[2] = 1'b1;
        end
      end

      // Refresh interval. The late flag fires once, on the cycle the gap
      // counter reaches the limit, and re-arms only on the next refresh.
      if (is_ar) begin
        err_next[3]     = |bank_open_reg;
        ref_cnt_next    = ref_cnt_reg + 16'd1;
        ref_gap_next    = '0;
        late_armed_next = 1'b1;
      end else begin
        if (ref_gap_reg != 12'hFFF) begin
          ref_gap_next = ref_gap_reg + 12'd1;
        end
        if (late_armed_reg && (ref_gap_next == REF_LIM)) begin
          err_next[5]     = 1'b1;
          late_armed_next = 1'b0;
        end
      end
    end
  end

  // Monitor state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= MON_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Gap counter, bank flags, refresh tracking and error reporting registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gap_reg        <= '0;
      bank_open_reg  <= '0;
      ref_gap_reg    <= '0;
      late_armed_reg <= 1'b0;
      ref_cnt_reg    <= '0;
      err_pulse_reg  <= '0;
      err_sticky_reg <= '0;
    end else begin
      gap_reg        <= gap_next;
      bank_open_reg  <= bank_open_next;
      ref_gap_reg    <= ref_gap_next;
      late_armed_reg <= late_armed_next;
      ref_cnt_reg    <= ref_cnt_next;
      err_pulse_reg  <= err_next;
      // A new pulse takes priority over a clear in the same cycle.
      err_sticky_reg <= (err_sticky_reg & ~{6{err_clr}}) | err_pulse_reg;
    end
  end

  // Per-bank tRCD counters.
  // Each counter restarts on ACTIVE to its bank and otherwise counts up,
  // saturating at 7.
  for (genvar gi = 0; gi < 4; gi++) begin : g_trcd
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        trcd_reg[gi] <= '0;
      end else if ((state_reg != MON_IDLE) && is_act && (ba == 2'(gi))) begin
        trcd_reg[gi] <= '0;
      end else if (trcd_reg[gi] != 3'd7) begin
        trcd_reg[gi] <= trcd_reg[gi] + 3'd1;
      end
    end
  end

  assign err_pulse  = err_pulse_reg;
  assign err_sticky = err_sticky_reg;
  assign ref_cnt    = ref_cnt_reg;
  assign bank_open  = bank_open_reg;
  assign mon_state  = state_reg;

endmodule

// File: tb/tb_sdram_cmd_mon.sv
// Directed bench for sdram_cmd_mon.
// Inputs change 1 ns after each rising edge. Outputs are compared at the same
// point, so each check sees the reaction to the command sampled on the edge
// just before it.
module tb_sdram_cmd_mon;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_AR  = 4'b0001;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [12:0] A10  = 13'h0400;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        init_end;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        err_clr;
  logic [5:0]  err_pulse;
  logic [5:0]  err_sticky;
  logic [15:0] ref_cnt;
  logic [3:0]  bank_open;
  logic [1:0]  mon_state;

  int n_checks = 0;
  int n_errors = 0;

  sdram_cmd_mon dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .init_end   (init_end),
    .cmd        (cmd),
    .ba         (ba),
    .addr       (addr),
    .err_clr    (err_clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .ref_cnt    (ref_cnt),
    .bank_open  (bank_open),
    .mon_state  (mon_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    cmd  = c;
    ba   = b;
    addr = a;
    tick();
  endtask

  initial begin
    int late_seen;
    sys_rst_n = 1'b0;
    init_end  = 1'b0;
    cmd       = C_NOP;
    ba        = 2'd0;
    addr      = '0;
    err_clr   = 1'b0;
    $display("step: reset asserted");
    tick();
    tick();
    chk("rst_err_pulse", 16'(err_pulse), 16'h0);
    chk("rst_err_sticky", 16'(err_sticky), 16'h0);
    chk("rst_ref_cnt", ref_cnt, 16'h0);
    chk("rst_bank_open", 16'(bank_open), 16'h0);
    chk("rst_mon_state", 16'(mon_state), 16'h0);
    sys_rst_n = 1'b1;

    // Commands before init are ignored.
    $display("step: idle PRE/AR/ACT before init_end");
    drive(C_PRE, 2'd0, 13'h0);
    drive(C_AR, 2'd0, 13'h0);
    chk("idle_err_pulse", 16'(err_pulse), 16'h0);
    chk("idle_ref_cnt", ref_cnt, 16'h0);
    chk("idle_state", 16'(mon_state), 16'h0);
    drive(C_ACT, 2'd0, 13'h0);
    chk("idle_bank_open", 16'(bank_open), 16'h0);

    // The AR sampled together with the first init_end is ignored.
    init_end = 1'b1;
    $display("step: init_end rises with AR on the bus");
    drive(C_AR, 2'd0, 13'h0);
    chk("init_state_ready", 16'(mon_state), 16'h1);
    chk("init_ref_cnt", ref_cnt, 16'h0);

    // Legal burst: PRE-all, 2 NOP, AR, 7 NOP, AR.
    $display("step: legal refresh burst");
    drive(C_PRE, 2'd0, A10);
    chk("burst_state_trp", 16'(mon_state), 16'h2);
    drive(C_NOP, 2'd0, 13'h0);
    chk("burst_trp_exit", 16'(mon_state), 16'h1);
    drive(C_NOP, 2'd0, 13'h0);
    drive(C_AR, 2'd0, 13'h0);
    chk("burst_state_trfc", 16'(mon_state), 16'h3);
    chk("burst_ref_cnt1", ref_cnt, 16'd1);
    repeat (5) drive(C_NOP, 2'd0, 13'h0);
    chk("burst_still_trfc", 16'(mon_state), 16'h3);
    drive(C_NOP, 2'd0, 13'h0);
    chk("burst_trfc_exit", 16'(mon_state), 16'h1);
    drive(C_NOP, 2'd0, 13'h0);
    drive(C_AR, 2'd0, 13'h0);
    chk("burst_err_pulse", 16'(err_pulse), 16'h0);
    chk("burst_ref_cnt2", ref_cnt, 16'd2);
    chk("burst_state_trfc2", 16'(mon_state), 16'h3);
    chk("burst_sticky", 16'(err_sticky), 16'h0);
    repeat (6) drive(C_NOP, 2'd0, 13'h0);
    chk("burst_final_ready", 16'(mon_state), 16'h1);

    // tRP violation: AR one cycle after PRE.
    $display("step: AR at gap 1 after PRE");
    drive(C_PRE, 2'd0, 13'h0);
    chk("trp_pre_err", 16'(err_pulse), 16'h0);
    drive(C_AR, 2'd0, 13'h0);
    chk("trp_err_pulse", 16'(err_pulse), 16'h01);
    chk("trp_state_trfc", 16'(mon_state), 16'h3);
    chk("trp_ref_cnt", ref_cnt, 16'd3);
    drive(C_NOP, 2'd0, 13'h0);
    chk("trp_pulse_once", 16'(err_pulse), 16'h0);
    chk("trp_sticky", 16'(err_sticky), 16'h01);
    err_clr = 1'b1;
    drive(C_NOP, 2'd0, 13'h0);
    err_clr = 1'b0;
    chk("trp_sticky_clr", 16'(err_sticky), 16'h0);
    repeat (4) drive(C_NOP, 2'd0, 13'h0);
    chk("trp_back_ready", 16'(mon_state), 16'h1);

    // Bank tracking and tRCD.
    $display("step: bank tracking on bank 2");
    drive(C_ACT, 2'd2, 13'h0);
    chk("act_bank_open", 16'(bank_open), 16'h4);
    chk("act_err", 16'(err_pulse), 16'h0);
    drive(C_RD, 2'd2, 13'h0);
    chk("trcd_early_rd", 16'(err_pulse), 16'h04);
    repeat (3) drive(C_NOP, 2'd0, 13'h0);
    drive(C_RD, 2'd2, 13'h0);
    chk("trcd_late_rd", 16'(err_pulse), 16'h0);
    drive(C_WR, 2'd1, 13'h0);
    chk("wr_closed_bank", 16'(err_pulse), 16'h04);
    drive(C_ACT, 2'd2, 13'h0);
    chk("act_open_bank", 16'(err_pulse), 16'h10);
    chk("act_open_bank_flags", 16'(bank_open), 16'h4);
    drive(C_AR, 2'd0, 13'h0);
    chk("ar_bank_open", 16'(err_pulse), 16'h08);
    chk("ar_ref_cnt", ref_cnt, 16'd4);
    drive(C_PRE, 2'd2, 13'h0);
    chk("pre_in_trfc", 16'(err_pulse), 16'h02);
    chk("pre_bank_closed", 16'(bank_open), 16'h0);
    chk("pre_state_trp", 16'(mon_state), 16'h2);
    drive(C_NOP, 2'd0, 13'h0);
    chk("bank_sticky", 16'(err_sticky), 16'h1E);
    chk("bank_ready", 16'(mon_state), 16'h1);
    err_clr = 1'b1;
    drive(C_NOP, 2'd0, 13'h0);
    err_clr = 1'b0;
    chk("bank_sticky_clr", 16'(err_sticky), 16'h0);

    // Refresh interval: late strobe fires once at gap 1562, not again.
    $display("step: refresh-late window");
    drive(C_AR, 2'd0, 13'h0);
    chk("late_ar_ref_cnt", ref_cnt, 16'd5);
    late_seen = 0;
    for (int i = 0; i < 1561; i++) begin
      drive(C_NOP, 2'd0, 13'h0);
      if (err_pulse[5]) late_seen++;
    end
    chk("late_not_early", 16'(late_seen), 16'h0);
    drive(C_NOP, 2'd0, 13'h0);
    chk("late_pulse", 16'(err_pulse), 16'h20);
    late_seen = 0;
    for (int i = 0; i < 2600; i++) begin
      drive(C_NOP, 2'd0, 13'h0);
      if (err_pulse[5]) late_seen++;
    end
    chk("late_no_repeat", 16'(late_seen), 16'h0);
    drive(C_AR, 2'd0, 13'h0);
    chk("rearm_ar_err", 16'(err_pulse), 16'h0);
    chk("rearm_ref_cnt", ref_cnt, 16'd6);
    late_seen = 0;
    for (int i = 0; i < 1562; i++) begin
      drive(C_NOP, 2'd0, 13'h0);
      if (err_pulse[5]) late_seen++;
    end
    chk("rearm_count", 16'(late_seen), 16'd1);
    chk("rearm_last", 16'(err_pulse), 16'h20);

    // Asynchronous reset in the middle of a tRFC window.
    $display("step: async reset inside MON_TRFC");
    drive(C_AR, 2'd0, 13'h0);
    drive(C_NOP, 2'd0, 13'h0);
    chk("pre_rst_state", 16'(mon_state), 16'h3);
    chk("pre_rst_sticky", 16'(err_sticky), 16'h20);
    chk("pre_rst_ref_cnt", ref_cnt, 16'd7);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_err_pulse", 16'(err_pulse), 16'h0);
    chk("arst_err_sticky", 16'(err_sticky), 16'h0);
    chk("arst_ref_cnt", ref_cnt, 16'h0);
    chk("arst_bank_open", 16'(bank_open), 16'h0);
    chk("arst_mon_state", 16'(mon_state), 16'h0);
    tick();
    sys_rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
